// File: rtl/sysid_arb_pkg.sv
// Shared definitions for the sysid round-robin arbiter and its helpers.
//   state_e          : arbiter FSM states
//   NUM_MASTERS_DEF  : default master count
//   DATA_W_DEF       : default readdata width
//   SYSID_ID/TS      : contents of the sysid slave (word 0 / word 1)
//   idx_w()          : width of an index into an n-entry vector
package sysid_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int NUM_MASTERS_DEF = 4;
  localparam int DATA_W_DEF      = 32;

  localparam logic [31:0] SYSID_ID = 32'h0000001E;
  localparam logic [31:0] SYSID_TS = 32'h666B285F;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i        : request vector
//   last_grant_i : index granted most recently
//   any_o        : at least one request present
//   winner_o     : first requester found searching upward from last_grant_i+1
module rr_pick
  import sysid_arb_pkg::*;
#(
  parameter int N  = NUM_MASTERS_DEF,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_grant_i,
  output logic          any_o,
  output logic [IW-1:0] winner_o
);

  int   idx;
  logic found;

  always_comb begin
    idx      = 0;
    found    = 1'b0;
    winner_o = '0;
    // Offsets 1..N visit every index once, ending on last_grant itself,
    // so the previous winner only wins again when it is alone.
    for (int off = 1; off <= N; off++) begin
      idx = int'(last_grant_i) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx[IW-1:0]]) begin
        found    = 1'b1;
        winner_o = idx[IW-1:0];
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/sysid_rr_arbiter.sv
// Round-robin arbiter sharing one combinational sysid slave among several
// Avalon read masters. Each request takes IDLE -> READ -> RESP (3 cycles).
//   clock_i           : system clock
//   reset_i           : asynchronous active-high reset
//   m_read_i          : per-master read request, held until accepted
//   m_address_i       : per-master word select (bit i = master i)
//   m_waitrequest_o   : per-master stall, low only in the completing cycle
//   m_readdatavalid_o : per-master one-cycle response strobe
//   m_readdata_o      : shared response bus
//   s_address_o       : word select to the sysid slave
//   s_readdata_i      : combinational sysid slave data
module sysid_rr_arbiter
  import sysid_arb_pkg::*;
#(
  parameter int NUM_MASTERS = NUM_MASTERS_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [NUM_MASTERS-1:0] m_read_i,
  input  logic [NUM_MASTERS-1:0] m_address_i,
  output logic [NUM_MASTERS-1:0] m_waitrequest_o,
  output logic [NUM_MASTERS-1:0] m_readdatavalid_o,
  output logic [DATA_W-1:0]      m_readdata_o,
  output logic                   s_address_o,
  input  logic [DATA_W-1:0]      s_readdata_i
);

  localparam int IW = idx_w(NUM_MASTERS);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);

  state_e              state_q, state_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [IW-1:0]       last_q, last_d;
  logic                addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                pick_any;
  logic [IW-1:0]       pick_idx;
  logic [NUM_MASTERS-1:0] resp_mask;

  rr_pick #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req_i        (m_read_i),
    .last_grant_i (last_q),
    .any_o        (pick_any),
    .winner_o     (pick_idx)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      addr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  // Requests are only looked at in IDLE; READ/RESP run to completion
  // regardless of what the granted master does with m_read.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          addr_d  = m_address_i[pick_idx];
          state_d = READ;
        end
      end
      READ: begin
        rdata_d = s_readdata_i;
        state_d = RESP;
      end
      RESP: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_mask = '0;
    if (state_q == RESP) resp_mask[grant_q] = 1'b1;
    m_readdatavalid_o = resp_mask;
    m_waitrequest_o   = m_read_i & ~resp_mask;
    m_readdata_o      = rdata_q;
    s_address_o       = addr_q;
  end

endmodule

// File: tb/tb_sysid_rr_arbiter.sv
module tb_sysid_rr_arbiter;
  import sysid_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic [N-1:0] m_read;
  logic [N-1:0] m_address;
  logic [N-1:0] m_waitrequest;
  logic [N-1:0] m_readdatavalid;
  logic [W-1:0] m_readdata;
  logic         s_address;
  logic [W-1:0] s_readdata;

  typedef struct {
    int          master;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  sysid_rr_arbiter #(.NUM_MASTERS(N), .DATA_W(W)) dut (
    .clock_i           (clock),
    .reset_i           (reset),
    .m_read_i          (m_read),
    .m_address_i       (m_address),
    .m_waitrequest_o   (m_waitrequest),
    .m_readdatavalid_o (m_readdatavalid),
    .m_readdata_o      (m_readdata),
    .s_address_o       (s_address),
    .s_readdata_i      (s_readdata)
  );

  // sysid slave model
  assign s_readdata = s_address ? SYSID_TS : SYSID_ID;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response strobe appears.
  always @(negedge clock) begin
    if (reset) begin
      chk("no_strobe_in_reset", {60'd0, m_readdatavalid}, 64'd0);
    end else if (|m_readdatavalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", {60'd0, m_readdatavalid}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rvalid_master", {60'd0, m_readdatavalid}, 64'(4'(1) << mon_e.master));
        chk("readdata", {32'd0, m_readdata}, {32'd0, mon_e.data});
        chk("resp_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("wait_low_in_resp", {63'd0, m_waitrequest[mon_e.master]}, 64'd0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b1;
    m_read = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Single read by one master; called just after a posedge with the FSM idle.
  task automatic do_read(input int m, input logic a);
    int k;
    k = cyc;
    m_read[m]    = 1'b1;
    m_address[m] = a;
    sb.push_back('{m, a ? SYSID_TS : SYSID_ID, k + 2});
    @(negedge clock);
    chk("wait_high_c1", {63'd0, m_waitrequest[m]}, 64'd1);
    @(negedge clock);
    chk("wait_high_c2", {63'd0, m_waitrequest[m]}, 64'd1);
    chk("s_address_read", {63'd0, s_address}, {63'd0, a});
    @(negedge clock);
    @(posedge clock);
    #1;
    m_read[m] = 1'b0;
  endtask

  initial begin
    int k;
    reset     = 1'b1;
    m_read    = 4'b0101;
    m_address = 4'b1111;
    #3;
    chk("rst_waitrequest", {60'd0, m_waitrequest}, 64'h5);
    chk("rst_rvalid", {60'd0, m_readdatavalid}, 64'd0);
    chk("rst_readdata", {32'd0, m_readdata}, 64'd0);
    chk("rst_s_address", {63'd0, s_address}, 64'd0);
    m_read    = '0;
    m_address = '0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // single master, then address select
    do_read(2, 1'b0);
    do_read(0, 1'b1);

    // contention: everybody requests continuously
    do_reset();
    k = cyc;
    m_read    = 4'hF;
    m_address = 4'b1010;
    sb.push_back('{0, SYSID_ID, k + 2});
    sb.push_back('{1, SYSID_TS, k + 5});
    sb.push_back('{2, SYSID_ID, k + 8});
    sb.push_back('{3, SYSID_TS, k + 11});
    sb.push_back('{0, SYSID_ID, k + 14});
    repeat (15) @(posedge clock);
    #1;
    m_read = '0;

    // rotation wrap from last_grant = 3
    do_reset();
    do_read(3, 1'b0);
    k = cyc;
    m_read    = 4'b1010;
    m_address = 4'b0010;
    sb.push_back('{1, SYSID_TS, k + 2});
    sb.push_back('{3, SYSID_ID, k + 5});
    repeat (3) @(posedge clock);
    #1;
    m_read = 4'b1000;
    repeat (3) @(posedge clock);
    #1;
    m_read = '0;

    // reset while in READ
    do_read(0, 1'b0);
    m_read    = 4'b0100;
    m_address = 4'b0100;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_rvalid", {60'd0, m_readdatavalid}, 64'd0);
    chk("midrst_readdata", {32'd0, m_readdata}, 64'd0);
    chk("midrst_s_address", {63'd0, s_address}, 64'd0);
    chk("midrst_waitrequest", {60'd0, m_waitrequest}, 64'h4);
    m_read = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    k = cyc;
    m_read    = 4'b0011;
    m_address = 4'b0010;
    sb.push_back('{0, SYSID_ID, k + 2});
    sb.push_back('{1, SYSID_TS, k + 5});
    repeat (3) @(posedge clock);
    #1;
    m_read = 4'b0010;
    repeat (3) @(posedge clock);
    #1;
    m_read = '0;

    // late arrival during RESP
    do_reset();
    k = cyc;
    m_read    = 4'b0001;
    m_address = 4'b0010;
    sb.push_back('{0, SYSID_ID, k + 2});
    sb.push_back('{1, SYSID_TS, k + 5});
    repeat (3) @(negedge clock);
    m_read[1] = 1'b1;
    #1;
    chk("late_wait_resp", {63'd0, m_waitrequest[1]}, 64'd1);
    @(posedge clock);
    #1;
    m_read[0] = 1'b0;
    @(negedge clock);
    chk("late_wait_idle", {63'd0, m_waitrequest[1]}, 64'd1);
    @(negedge clock);
    chk("late_wait_read", {63'd0, m_waitrequest[1]}, 64'd1);
    @(negedge clock);
    @(posedge clock);
    #1;
    m_read = '0;

    repeat (4) @(posedge clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
